// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter.
//   NUM_SRC         default number of interrupt sources
//   SRC_*           bit positions of the named sources on src_irq
//   state_t         arbiter FSM state encoding
package irq_pkg;

  localparam int unsigned NUM_SRC = 4;

  localparam int unsigned SRC_TIMER   = 0;
  localparam int unsigned SRC_UART_RX = 1;
  localparam int unsigned SRC_UART_TX = 2;
  localparam int unsigned SRC_EXT     = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

endpackage

// File: rtl/irq_arbiter_if.sv
// Control-unit / register-bus side of the interrupt arbiter.
//   pc_31, irq_take                 pipeline status into the arbiter
//   mask_wr/mask_wdata              mask register write
//   clr_wr/clr_wdata                write-1-to-clear of pending bits
//   irq, cause, in_service          request handshake towards the pipeline
//   pending, mask                   register read-back
// slave  : the arbiter
// master : the CPU / control unit
interface irq_arbiter_if #(
  parameter int unsigned NUM_SRC = 4
);
  logic               pc_31;
  logic               irq_take;
  logic               mask_wr;
  logic [NUM_SRC-1:0] mask_wdata;
  logic               clr_wr;
  logic [NUM_SRC-1:0] clr_wdata;
  logic               irq;
  logic [1:0]         cause;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic               in_service;

  modport slave (
    input  pc_31, irq_take, mask_wr, mask_wdata, clr_wr, clr_wdata,
    output irq, cause, pending, mask, in_service
  );

  modport master (
    output pc_31, irq_take, mask_wr, mask_wdata, clr_wr, clr_wdata,
    input  irq, cause, pending, mask, in_service
  );
endinterface

// File: rtl/irq_arbiter_prio_enc.sv
// Fixed-priority encoder: the lowest set bit of eligible wins.
//   eligible  in   candidate sources
//   index     out  position of the winning source
//   valid     out  at least one candidate present
module irq_prio_enc #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] eligible,
  output logic [IDX_W-1:0]   index,
  output logic               valid
);

  // Scan from the top down so the lowest set bit is written last.
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (eligible[i-1]) begin
        index = IDX_W'(i - 1);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: edge-detects sources into a pending register, masks
// them, picks the lowest-index eligible source and runs the
// IDLE -> REQ -> SERVICE -> HOLDOFF request handshake with the pipeline.
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   src_irq  in   raw source lines
//   bus      slave side of irq_arbiter_if (handshake + register access)
module irq_arbiter #(
  parameter int unsigned NUM_SRC = irq_pkg::NUM_SRC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  irq_arbiter_if.slave       bus
);

  import irq_pkg::*;

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t             state, state_nx;
  logic [NUM_SRC-1:0] src_q, rise, clr_vec;
  logic [NUM_SRC-1:0] pending_q, pending_nx, mask_q, mask_nx, eligible;
  logic               armed, pc_q;
  logic [1:0]         cause_q;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;

  // Edge detection is disarmed for the first cycle after reset so a line
  // already high at release is absorbed into src_q instead of looking new.
  always_comb begin
    rise       = armed ? (src_irq & ~src_q) : '0;
    clr_vec    = bus.clr_wr ? bus.clr_wdata : '0;
    pending_nx = (pending_q & ~clr_vec) | rise;
    mask_nx    = bus.mask_wr ? bus.mask_wdata : mask_q;
    eligible   = pending_q & mask_q;
  end

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .eligible (eligible),
    .index    (grant_idx),
    .valid    (grant_vld)
  );

  // Withdrawal looks at the pending/mask values being written this edge, so
  // the state leaves REQ on the same edge that eligible becomes zero.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant_vld && !bus.pc_31) state_nx = REQ;
      REQ: begin
        if (bus.irq_take)                      state_nx = SERVICE;
        else if ((pending_nx & mask_nx) == '0) state_nx = IDLE;
      end
      SERVICE: if (pc_q && !bus.pc_31) state_nx = HOLDOFF;
      HOLDOFF: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      src_q     <= '0;
      armed     <= 1'b0;
      pc_q      <= 1'b0;
      pending_q <= '0;
      mask_q    <= '0;
      cause_q   <= '0;
    end else begin
      state     <= state_nx;
      src_q     <= src_irq;
      armed     <= 1'b1;
      pc_q      <= bus.pc_31;
      pending_q <= pending_nx;
      mask_q    <= mask_nx;
      if (state == IDLE && state_nx == REQ) cause_q <= 2'(grant_idx);
    end
  end

  assign bus.irq        = (state == REQ);
  assign bus.in_service = (state == SERVICE);
  assign bus.cause      = cause_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;

endmodule

// File: tb/tb_irq_arbiter.sv
module tb_irq_arbiter;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] src_irq = '0;

  irq_arbiter_if #(.NUM_SRC(N)) bus ();

  irq_arbiter #(.NUM_SRC(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .src_irq (src_irq),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model: handshake phase held as three flags (requesting,
  // servicing, holding off); all clear means idle.
  logic [3:0] m_pend, m_mask, m_src_prev;
  logic       m_armed, m_pc_prev, m_irq, m_srv, m_hold;
  logic [1:0] m_cause;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_src_prev = '0;
    m_armed = 1'b0; m_pc_prev = 1'b0;
    m_irq = 1'b0; m_srv = 1'b0; m_hold = 1'b0; m_cause = 2'd0;
  endtask

  // Compute the model's next state from the inputs present before the edge,
  // advance one clock, then commit.
  task automatic tick();
    logic [3:0] rise, clr, n_pend, n_mask;
    logic       n_irq, n_srv, n_hold, live;
    logic [1:0] n_cause;
    live = reset;
    rise = m_armed ? (src_irq & ~m_src_prev) : 4'b0;
    clr  = bus.clr_wr ? bus.clr_wdata : 4'b0;
    n_pend = (m_pend & ~clr) | rise;
    n_mask = bus.mask_wr ? bus.mask_wdata : m_mask;
    n_irq = m_irq; n_srv = m_srv; n_hold = m_hold; n_cause = m_cause;
    if (m_irq) begin
      if (bus.irq_take) begin n_irq = 1'b0; n_srv = 1'b1; end
      else if ((n_pend & n_mask) == 4'b0) n_irq = 1'b0;
    end else if (m_srv) begin
      if (m_pc_prev && !bus.pc_31) begin n_srv = 1'b0; n_hold = 1'b1; end
    end else if (m_hold) begin
      n_hold = 1'b0;
    end else if ((m_pend & m_mask) != 4'b0 && !bus.pc_31) begin
      n_irq = 1'b1;
      n_cause = lowest(m_pend & m_mask);
    end
    @(posedge clk);
    #1;
    if (live) begin
      m_pend = n_pend; m_mask = n_mask; m_src_prev = src_irq;
      m_armed = 1'b1; m_pc_prev = bus.pc_31;
      m_irq = n_irq; m_srv = n_srv; m_hold = n_hold; m_cause = n_cause;
    end else begin
      model_reset();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_irq"}, bus.irq, 0);
    check({tag, "_cause"}, bus.cause, 0);
    check({tag, "_pending"}, bus.pending, 0);
    check({tag, "_mask"}, bus.mask, 0);
    check({tag, "_in_service"}, bus.in_service, 0);
  endtask

  // Asserts reset between clock edges, holds it two cycles, then releases.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all_zero(tag);
    repeat (2) tick();
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_irq", bus.irq, m_irq);
      check("cyc_cause", bus.cause, m_cause);
      check("cyc_pending", bus.pending, m_pend);
      check("cyc_mask", bus.mask, m_mask);
      check("cyc_in_service", bus.in_service, m_srv);
    end
  end

  initial begin
    bus.pc_31 = 1'b0; bus.irq_take = 1'b0;
    bus.mask_wr = 1'b0; bus.mask_wdata = '0;
    bus.clr_wr = 1'b0; bus.clr_wdata = '0;
    model_reset();
    tick();
    check_all_zero("rst");
    tick();
    reset = 1'b1;
    tick();
    chk_en = 1'b1;

    // irq_take while idle is ignored
    bus.irq_take = 1'b1; tick(); bus.irq_take = 1'b0;
    check("take_idle_in_service", bus.in_service, 0);

    // Single source, two-cycle latency
    bus.mask_wr = 1'b1; bus.mask_wdata = 4'hF; tick(); bus.mask_wr = 1'b0;
    check("mask_load", bus.mask, 4'hF);
    src_irq = 4'b0010; tick();
    check("s1_pending", bus.pending, 4'b0010);
    check("s1_irq_early", bus.irq, 0);
    tick();
    check("s1_irq", bus.irq, 1);
    check("s1_cause", bus.cause, 1);

    // Withdrawal drops irq on the clearing edge
    bus.clr_wr = 1'b1; bus.clr_wdata = 4'b0010; tick(); bus.clr_wr = 1'b0;
    check("wd1_irq", bus.irq, 0);
    check("wd1_pending", bus.pending, 0);

    // Simultaneous sources, priority, cause held in REQ
    src_irq = 4'b1011; tick(); tick();
    check("s2_irq", bus.irq, 1);
    check("s2_cause", bus.cause, 0);
    src_irq = 4'b1111; tick(); tick();
    check("s2_cause_held", bus.cause, 0);
    check("s2_pending", bus.pending, 4'b1101);

    // Take, service, handler return, holdoff, re-request
    bus.irq_take = 1'b1; tick(); bus.irq_take = 1'b0;
    check("s3_in_service", bus.in_service, 1);
    check("s3_irq", bus.irq, 0);
    bus.pc_31 = 1'b1; bus.clr_wr = 1'b1; bus.clr_wdata = 4'b0001; tick();
    bus.clr_wr = 1'b0;
    repeat (4) tick();
    check("s3_still_service", bus.in_service, 1);
    check("s3_pending", bus.pending, 4'b1100);
    bus.pc_31 = 1'b0; tick();
    check("s3_holdoff_srv", bus.in_service, 0);
    check("s3_holdoff_irq", bus.irq, 0);
    tick();
    check("s3_idle_irq", bus.irq, 0);
    tick();
    check("s3_rereq_irq", bus.irq, 1);
    check("s3_rereq_cause", bus.cause, 2);

    // Clear everything while requesting
    bus.clr_wr = 1'b1; bus.clr_wdata = 4'b1100; tick(); bus.clr_wr = 1'b0;
    check("s4_irq", bus.irq, 0);

    // Set and clear of the same bit in one cycle: set wins
    src_irq = 4'b0000; tick();
    src_irq = 4'b0001; bus.clr_wr = 1'b1; bus.clr_wdata = 4'b0001; tick();
    bus.clr_wr = 1'b0;
    check("s4_set_wins", bus.pending, 4'b0001);
    tick();
    check("s4_req_irq", bus.irq, 1);
    check("s4_req_cause", bus.cause, 0);
    bus.clr_wr = 1'b1; bus.clr_wdata = 4'b0001; tick(); bus.clr_wr = 1'b0;
    check("s4_withdraw_irq", bus.irq, 0);

    // Reset during service with source 0 held high
    src_irq = 4'b0101; tick(); tick();
    check("s5_cause", bus.cause, 2);
    bus.irq_take = 1'b1; tick(); bus.irq_take = 1'b0;
    check("s5_in_service", bus.in_service, 1);
    src_irq = 4'b0001;
    do_reset("s5_rst");
    repeat (3) tick();
    check("s5_no_pending", bus.pending, 0);
    check("s5_idle_srv", bus.in_service, 0);
    check("s5_idle_irq", bus.irq, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) src_irq = src_irq ^ 4'($urandom_range(1, 15));
      if ($urandom_range(0, 5) == 0) bus.pc_31 = ~bus.pc_31;
      bus.irq_take   = ($urandom_range(0, 3) == 0);
      bus.mask_wr    = ($urandom_range(0, 15) == 0);
      bus.mask_wdata = 4'($urandom);
      bus.clr_wr     = ($urandom_range(0, 5) == 0);
      bus.clr_wdata  = 4'($urandom);
      tick();
      if (c == 1500) do_reset("rnd_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
